psum_deskew_fifo: RTL and testbench
===================================

Name: psum_deskew_fifo

Overview:
- Sits directly downstream of the 4-row PE array and consumes its four 16-bit FP16 row results (out1..out4).
- Row k of the array receives weights k-1 cycles late, so results for one output column arrive skewed by one cycle per row.
- The block deskews the four rows into one aligned 64-bit word and buffers it in a first-word-fall-through FIFO.
- Words leave through a valid/ready interface to the writeback stage. Overflow is flagged, never silent.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 2.
- W, 16, width of one row result; FP16 layout: sign bit [15], exponent [14:10], mantissa [9:0].

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  row-1 result on row_in1 is valid this cycle; defines the column timestamp t.
- row_in1  input  W  PE row 1 result, valid at t.
- row_in2  input  W  PE row 2 result, valid at t+1.
- row_in3  input  W  PE row 3 result, valid at t+2.
- row_in4  input  W  PE row 4 result, valid at t+3.
- clr  input  1  synchronous clear: flushes the FIFO, the valid pipeline and the overflow flag.
- o_data  output  4*W  aligned word {row4,row3,row2,row1}.
- o_valid  output  1  o_data holds the FIFO head.
- o_ready  input  1  downstream accepts o_data when o_valid & o_ready.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  output  1  sticky flag: an aligned word was dropped because the FIFO was full.

Behaviour:
- Reset (rst=0, asynchronous): all deskew registers, FIFO pointers and the valid pipe clear. o_valid=0, o_data=0, level=0, overflow=0.
- Deskew:
  - row_in1 is delayed 3 registers, row_in2 2, row_in3 1, row_in4 0.
  - in_valid is delayed 3 registers in a valid pipe.
  - At t+3 all four rows and the delayed valid (wr_req) are aligned.
- Write: when wr_req=1 and the FIFO is not full, the aligned word is written at cycle t+3. Deskew registers shift every cycle regardless of in_valid.
- Read:
  - FWFT. o_valid=1 whenever level>0, and o_data is the head entry.
  - A pop occurs when o_valid & o_ready.
- Latency: in_valid at t gives o_valid=1 at t+4 when the FIFO was empty.
- Throughput: back-to-back in_valid is allowed. Each cycle of in_valid produces one word.
- Full:
  - If wr_req=1, level==DEPTH and no pop happens in the same cycle, the word is dropped, overflow is set and level is unchanged.
  - If a pop happens in the same cycle, the write is accepted and level stays at DEPTH.
- Empty: o_ready with o_valid=0 has no effect. A write to an empty FIFO is visible at o_data the following cycle (no combinational bypass).
- Simultaneous push and pop: level is unchanged and both pointers advance, wrapping modulo DEPTH.
- Pointers use an extra wrap bit: full = (wr_ptr ^ rd_ptr) == DEPTH, empty = pointers equal.
- clr:
  - Pointers, level and overflow go to 0. The valid pipe clears, so words in flight are discarded; deskew data registers may keep stale data.
  - clr has priority over a simultaneous push or pop.
  - Rows presented in cycles after clr deasserts are handled normally.
- Reset mid-operation: all buffered and in-flight words are lost. o_valid drops immediately (asynchronously) and does not rise again until a new in_valid has passed the full 4-cycle latency.
- Data is not modified (no arithmetic) unless the optional feature is enabled.

Optional Feature:
- Macro PSUM_RELU_EN.
- Defined: ReLU on each aligned row value before the FIFO write. If bit [W-1]=1 (negative, including -0), the value is replaced with 16'h0000; otherwise it passes unchanged. No added latency.
- Undefined: values are written unchanged.

Test Plan:
- Single column: in_valid at t with row_in1=16'h3C00, then row_in2=16'h4000 at t+1, row_in3=16'h4200 at t+2, row_in4=16'h4400 at t+3, o_ready=1 -> at t+4 o_valid=1, o_data=64'h4400_4200_4000_3C00; o_valid=0 at t+5.
- Streaming: 10 consecutive columns, column n carrying value n in every row, o_ready=1 -> 10 consecutive words in order n=0..9, level never exceeds 1, overflow=0.
- Full/overflow: DEPTH=8, o_ready=0, 9 columns -> level=8, the 9th word is dropped and overflow=1. Then o_ready=1 -> exactly words 0..7 drain and level returns to 0.
- Push and pop at full: level=8 with wr_req and o_ready=1 in the same cycle -> write accepted, level stays 8, overflow stays 0, order preserved through pointer wrap.
- clr and reset: 3 words buffered plus 2 in flight, clr pulsed -> level=0, o_valid=0, no in-flight word appears. Repeat with rst=0 mid-cycle -> all outputs 0 immediately.
- PSUM_RELU_EN defined: rows {16'hBC00, 16'h3C00, 16'h8000, 16'h7BFF} -> o_data=64'h7BFF_0000_3C00_0000. Same stimulus with the macro undefined -> o_data=64'h7BFF_8000_3C00_BC00.

Source files
------------

// File: rtl/psum_deskew_fifo.sv
// psum_deskew_fifo: aligns the four skewed PE row results into one word and buffers it in an FWFT FIFO.
// Optional ReLU on each row before the write is enabled with `define PSUM_RELU_EN.
module psum_deskew_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [W-1:0]            row_in1,
  input  logic [W-1:0]            row_in2,
  input  logic [W-1:0]            row_in3,
  input  logic [W-1:0]            row_in4,
  input  logic                    clr,
  output logic [4*W-1:0]          o_data,
  output logic                    o_valid,
  input  logic                    o_ready,
  output logic [$clog2(DEPTH):0]  level,
  output logic                    overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [2:0][W-1:0] r1_q;
  logic [1:0][W-1:0] r2_q;
  logic [W-1:0]      r3_q;
  logic [2:0]        v_q;
  logic [AW:0]       wr_ptr, rd_ptr;
  logic [4*W-1:0]    mem [DEPTH];
  logic [4*W-1:0]    aligned, wr_data;
  logic              wr_req, full, pop, push;
  assign aligned = {row_in4, r3_q, r2_q[1], r1_q[2]};
  assign wr_req  = v_q[2];
`ifdef PSUM_RELU_EN
  for (genvar i = 0; i < 4; i++) begin : g_relu
    assign wr_data[i*W +: W] = aligned[i*W+W-1] ? '0 : aligned[i*W +: W];
  end
`else
  assign wr_data = aligned;
`endif
  assign full    = (wr_ptr ^ rd_ptr) == (AW+1)'(DEPTH);
  assign o_valid = wr_ptr != rd_ptr;
  assign level   = wr_ptr - rd_ptr;
  assign pop     = o_valid & o_ready;
  assign push    = wr_req & (!full | pop);
  // gate the head so an empty FIFO (or one just reset) never exposes stale memory
  assign o_data  = o_valid ? mem[rd_ptr[AW-1:0]] : '0;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r1_q <= '0;
      r2_q <= '0;
      r3_q <= '0;
      v_q  <= '0;
    end else begin
      r1_q <= {r1_q[1:0], row_in1};
      r2_q <= {r2_q[0], row_in2};
      r3_q <= row_in3;
      v_q  <= clr ? '0 : {v_q[1:0], in_valid};
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      wr_ptr   <= push ? wr_ptr + (AW+1)'(1) : wr_ptr;
      rd_ptr   <= pop ? rd_ptr + (AW+1)'(1) : rd_ptr;
      overflow <= overflow | (wr_req & full & !pop);
    end
  always_ff @(posedge clk)
    if (push & !clr) mem[wr_ptr[AW-1:0]] <= wr_data;
endmodule

// File: tb/tb_psum_deskew_fifo.sv
// tb_psum_deskew_fifo: directed bench for the deskew FIFO with hand-computed expectations.
module tb_psum_deskew_fifo;
  logic        clk = 0, rst = 0, in_valid = 0, clr = 0, o_ready = 0;
  logic [15:0] row_in1 = 0, row_in2 = 0, row_in3 = 0, row_in4 = 0;
  logic [63:0] o_data;
  logic        o_valid, overflow;
  logic [3:0]  level;
  int          checks = 0, errors = 0;
  always #5 clk = ~clk;
  psum_deskew_fifo #(.DEPTH(8), .W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .row_in1(row_in1), .row_in2(row_in2), .row_in3(row_in3), .row_in4(row_in4),
    .clr(clr), .o_data(o_data), .o_valid(o_valid), .o_ready(o_ready),
    .level(level), .overflow(overflow)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b,
                      input logic [15:0] c, input logic [15:0] d, input logic rdy, input logic cl);
    @(posedge clk);
    #1;
    in_valid = v;
    row_in1 = a;
    row_in2 = b;
    row_in3 = c;
    row_in4 = d;
    o_ready = rdy;
    clr = cl;
    @(negedge clk);
  endtask
  function automatic logic [15:0] cv(input int k, input int n, input int base);
    return (k >= 0 && k < n) ? 16'(base + k) : 16'h0000;
  endfunction
  // cycle k of a stream of n columns: row i carries column k-(i-1)
  task automatic col(input int k, input int n, input int base, input logic rdy, input logic cl);
    step(k < n, cv(k, n, base), cv(k-1, n, base), cv(k-2, n, base), cv(k-3, n, base), rdy, cl);
  endtask
  function automatic logic [63:0] wd(input int v);
    return {4{16'(v)}};
  endfunction
  initial begin
    #3;
    chk("rst_valid", o_valid, 0);
    chk("rst_data", o_data, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", overflow, 0);
    #9 rst = 1;
    step(1, 16'h3C00, 0, 0, 0, 1, 0);
    step(0, 0, 16'h4000, 0, 0, 1, 0);
    step(0, 0, 0, 16'h4200, 0, 1, 0);
    step(0, 0, 0, 0, 16'h4400, 1, 0);
    chk("single_t3_valid", o_valid, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("single_t4_valid", o_valid, 1);
    chk("single_t4_data", o_data, 64'h4400_4200_4000_3C00);
    chk("single_t4_level", level, 1);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("single_t5_valid", o_valid, 0);
    chk("single_t5_level", level, 0);
    for (int k = 0; k < 14; k++) begin
      col(k, 10, 0, 1, 0);
      if (k >= 4) begin
        chk("stream_valid", o_valid, 1);
        chk("stream_data", o_data, wd(k-4));
        chk("stream_level", level, 1);
      end else chk("stream_idle", o_valid, 0);
    end
    chk("stream_ovf", overflow, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("stream_end_level", level, 0);
    for (int k = 0; k < 13; k++) begin
      col(k, 9, 16'h100, 0, 0);
      if (k == 11) begin
        chk("full_level", level, 8);
        chk("full_ovf_before", overflow, 0);
      end
    end
    chk("ovf_level", level, 8);
    chk("ovf_set", overflow, 1);
    chk("ovf_head", o_data, wd(16'h100));
    for (int j = 0; j < 8; j++) begin
      step(0, 0, 0, 0, 0, 1, 0);
      chk("drain_data", o_data, wd(16'h100 + j));
      chk("drain_level", level, 64'(8 - j));
    end
    step(0, 0, 0, 0, 0, 1, 0);
    chk("drain_empty", o_valid, 0);
    chk("drain_level0", level, 0);
    chk("drain_ovf_sticky", overflow, 1);
    for (int k = 0; k < 7; k++) col(k, 5, 16'h300, 0, k == 6);
    chk("clr_pre_level", level, 3);
    chk("clr_pre_head", o_data, wd(16'h300));
    for (int k = 7; k < 11; k++) begin
      col(k, 5, 16'h300, 0, 0);
      chk("clr_level", level, 0);
      chk("clr_valid", o_valid, 0);
      chk("clr_ovf", overflow, 0);
    end
    for (int k = 0; k < 12; k++) col(k, 9, 16'h200, k == 11, 0);
    chk("pp_level", level, 8);
    chk("pp_head", o_data, wd(16'h200));
    for (int j = 1; j < 9; j++) begin
      step(0, 0, 0, 0, 0, 1, 0);
      chk("pp_data", o_data, wd(16'h200 + j));
      chk("pp_level", level, 64'(9 - j));
      chk("pp_ovf", overflow, 0);
    end
    step(0, 0, 0, 0, 0, 1, 0);
    chk("pp_empty", level, 0);
    step(1, 16'hBC00, 0, 0, 0, 1, 0);
    step(0, 0, 16'h3C00, 0, 0, 1, 0);
    step(0, 0, 0, 16'h8000, 0, 1, 0);
    step(0, 0, 0, 0, 16'h7BFF, 1, 0);
    step(0, 0, 0, 0, 0, 1, 0);
    chk("relu_valid", o_valid, 1);
`ifdef PSUM_RELU_EN
    chk("relu_data", o_data, 64'h7BFF_0000_3C00_0000);
`else
    chk("relu_data", o_data, 64'h7BFF_8000_3C00_BC00);
`endif
    step(0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 8; k++) col(k, 6, 16'h400, 0, 0);
    chk("mid_level", level, 4);
    #2 rst = 0;
    #1;
    chk("mid_rst_valid", o_valid, 0);
    chk("mid_rst_data", o_data, 0);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_ovf", overflow, 0);
    #4 rst = 1;
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 0, 1, 0);
      chk("post_rst_idle", o_valid, 0);
    end
    for (int k = 0; k < 5; k++) begin
      col(k, 1, 16'h500, 1, 0);
      chk("post_rst_lat", o_valid, k == 4);
    end
    chk("post_rst_data", o_data, wd(16'h500));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
